// File: rtl/mmu_ptw_responder.sv
// MMU page-table-walk responder: queues walk requests, fetches 64-bit lines, holds each response until taken.
// Latency: 1 cycle request->oMEM_REQ from empty; oMMU_VALID 1 cycle after iMEM_VALID; optional cache hit 1 cycle.
// Backpressure: oMMU_LOCK when queue full; oMEM_REQ held while iMEM_LOCK; response held while iMMU_LOCK.
//
// Ports: iCLOCK/iRESET (sync, active-high); iFLUSH invalidates the line cache.
//   MMU side: iMMU_REQ/oMMU_LOCK/iMMU_ADDR requests, oMMU_VALID/iMMU_LOCK/oMMU_DATA responses.
//   Memory side: oMEM_REQ/iMEM_LOCK/oMEM_ADDR requests, iMEM_VALID/oMEM_LOCK/iMEM_DATA read data.
//   oERROR pulses for one cycle when a fetch is abandoned by the watchdog.
// Optional one-entry line cache: define MMU_PTW_LINE_CACHE_EN.

// Generic request FIFO; also exposes the entry behind the head so a pop can chain straight into the next fetch.
// Latency: write visible at head one cycle after push.
// Backpressure: none internally; the caller must not push when count==DEPTH.
module mmu_ptw_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 31
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [W-1:0]           next_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];
    assign next_dat = mem[rd_ptr + AW'(1)];

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_vld && !pop_vld) begin
                count <= count + CW'(1);
            end else if (!push_vld && pop_vld) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module mmu_ptw_responder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iFLUSH,
    input  logic        iMMU_REQ,
    output logic        oMMU_LOCK,
    input  logic [31:0] iMMU_ADDR,
    output logic        oMMU_VALID,
    input  logic        iMMU_LOCK,
    output logic [63:0] oMMU_DATA,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    output logic        oMEM_LOCK,
    input  logic [63:0] iMEM_DATA,
    output logic        oERROR
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    state_t        state;
    logic [WW-1:0] wdog;
    logic          push;
    logic          pop;
    logic [30:0]   head_line;
    logic [30:0]   next_line;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [30:0]   cur_line;
    logic          cur_avail;
    logic [30:0]   nxt_line;
    logic          nxt_avail;
    logic          cur_hit;
    logic          nxt_hit;
    logic [63:0]   hit_dat;
    logic          timeout;
    logic          unused_addr0;

    // Only the line address is queued; the word-select bit never reaches memory.
    assign unused_addr0 = iMMU_ADDR[0];

    assign push = iMMU_REQ && !oMMU_LOCK;
    assign pop  = (state == ST_RESP) && !iMMU_LOCK;

    mmu_ptw_fifo #(.DEPTH(DEPTH), .W(31)) u_req_fifo (
        .iCLOCK   (iCLOCK),
        .iRESET   (iRESET),
        .push_vld (push),
        .push_dat (iMMU_ADDR[31:1]),
        .pop_vld  (pop),
        .head_dat (head_line),
        .next_dat (next_line),
        .count    (count)
    );

    // Head as seen this cycle: an empty queue forwards the request being pushed so IDLE reacts at once.
    assign cur_line  = (count == '0) ? iMMU_ADDR[31:1] : head_line;
    assign cur_avail = (count != '0) || push;
    // Head after the RESP pop: the entry behind the current head, or the concurrent push if none.
    assign nxt_line  = (count > CW'(1)) ? next_line : iMMU_ADDR[31:1];
    assign nxt_avail = (count > CW'(1)) || push;

    assign timeout = (state == ST_WAIT) && !iMEM_VALID && (wdog == WW'(TIMEOUT - 1));

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

`ifdef MMU_PTW_LINE_CACHE_EN
    logic [30:0] cache_tag;
    logic [63:0] cache_dat;
    logic        cache_vld;

    // A flush in the decision cycle already counts as a miss.
    assign cur_hit = cache_vld && !iFLUSH && (cur_line == cache_tag);
    assign nxt_hit = cache_vld && !iFLUSH && (nxt_line == cache_tag);
    assign hit_dat = cache_dat;

    // oMEM_ADDR still holds the line being fetched throughout WAIT, so it doubles as the fill tag.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            cache_vld <= 1'b0;
        end else if ((state == ST_WAIT) && iMEM_VALID) begin
            cache_tag <= oMEM_ADDR[31:1];
            cache_dat <= iMEM_DATA;
            cache_vld <= !iFLUSH;
        end else if (timeout || iFLUSH) begin
            cache_vld <= 1'b0;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = iFLUSH;
    assign cur_hit      = 1'b0;
    assign nxt_hit      = 1'b0;
    assign hit_dat      = '0;
`endif

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state      <= ST_IDLE;
            wdog       <= '0;
            oMMU_VALID <= 1'b0;
            oMMU_DATA  <= '0;
            oMEM_REQ   <= 1'b0;
            oMEM_ADDR  <= '0;
            oMEM_LOCK  <= 1'b1;
            oMMU_LOCK  <= 1'b0;
            oERROR     <= 1'b0;
        end else begin
            oERROR    <= 1'b0;
            // Track the post-update count so the lock is never a cycle stale.
            oMMU_LOCK <= (count_nxt == CW'(DEPTH));
            case (state)
                ST_IDLE: begin
                    if (cur_avail) begin
                        if (cur_hit) begin
                            state      <= ST_RESP;
                            oMMU_VALID <= 1'b1;
                            oMMU_DATA  <= hit_dat;
                        end else begin
                            state     <= ST_REQ;
                            oMEM_REQ  <= 1'b1;
                            oMEM_ADDR <= {cur_line, 1'b0};
                        end
                    end
                end
                ST_REQ: begin
                    if (!iMEM_LOCK) begin
                        state     <= ST_WAIT;
                        oMEM_REQ  <= 1'b0;
                        oMEM_LOCK <= 1'b0;
                        wdog      <= '0;
                    end
                end
                ST_WAIT: begin
                    // Data arriving on the last watchdog cycle still wins over the timeout.
                    if (iMEM_VALID) begin
                        state      <= ST_RESP;
                        oMEM_LOCK  <= 1'b1;
                        oMMU_VALID <= 1'b1;
                        oMMU_DATA  <= iMEM_DATA;
                    end else if (timeout) begin
                        state      <= ST_RESP;
                        oMEM_LOCK  <= 1'b1;
                        oMMU_VALID <= 1'b1;
                        oMMU_DATA  <= '0;
                        oERROR     <= 1'b1;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                ST_RESP: begin
                    if (!iMMU_LOCK) begin
                        oMMU_VALID <= 1'b0;
                        if (!nxt_avail) begin
                            state <= ST_IDLE;
                        end else if (nxt_hit) begin
                            oMMU_VALID <= 1'b1;
                            oMMU_DATA  <= hit_dat;
                        end else begin
                            state     <= ST_REQ;
                            oMEM_REQ  <= 1'b1;
                            oMEM_ADDR <= {nxt_line, 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_ptw_responder.sv
// Bench for mmu_ptw_responder: directed scenarios followed by a randomized run against a transaction model.
// Latency: n/a.
// Backpressure: the bench drives iMEM_LOCK/iMMU_LOCK both directed and at random.
module tb_mmu_ptw_responder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iFLUSH;
    logic        iMMU_REQ;
    logic        oMMU_LOCK;
    logic [31:0] iMMU_ADDR;
    logic        oMMU_VALID;
    logic        iMMU_LOCK;
    logic [63:0] oMMU_DATA;
    logic        oMEM_REQ;
    logic        iMEM_LOCK;
    logic [31:0] oMEM_ADDR;
    logic        iMEM_VALID;
    logic        oMEM_LOCK;
    logic [63:0] iMEM_DATA;
    logic        oERROR;

    int errs   = 0;
    int checks = 0;

    mmu_ptw_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .iCLOCK     (iCLOCK),
        .iRESET     (iRESET),
        .iFLUSH     (iFLUSH),
        .iMMU_REQ   (iMMU_REQ),
        .oMMU_LOCK  (oMMU_LOCK),
        .iMMU_ADDR  (iMMU_ADDR),
        .oMMU_VALID (oMMU_VALID),
        .iMMU_LOCK  (iMMU_LOCK),
        .oMMU_DATA  (oMMU_DATA),
        .oMEM_REQ   (oMEM_REQ),
        .iMEM_LOCK  (iMEM_LOCK),
        .oMEM_ADDR  (oMEM_ADDR),
        .iMEM_VALID (iMEM_VALID),
        .oMEM_LOCK  (oMEM_LOCK),
        .iMEM_DATA  (iMEM_DATA),
        .oERROR     (oERROR)
    );

    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents as a pure function of the line address.
    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

    function automatic logic [63:0] line_data(input logic [31:0] a);
        logic [31:0] l;
        l = line_of(a);
        return {l ^ 32'hC0DE_0000, ~l};
    endfunction

    // Inputs set before tick() are sampled on that edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string t);
        chk({t, ".mmu_valid"}, 64'(oMMU_VALID), 64'd0);
        chk({t, ".mmu_data"},  oMMU_DATA,        64'd0);
        chk({t, ".mem_req"},   64'(oMEM_REQ),   64'd0);
        chk({t, ".mem_addr"},  64'(oMEM_ADDR),  64'd0);
        chk({t, ".mem_lock"},  64'(oMEM_LOCK),  64'd1);
        chk({t, ".mmu_lock"},  64'(oMMU_LOCK),  64'd0);
        chk({t, ".error"},     64'(oERROR),     64'd0);
    endtask

    task automatic push_req(input logic [31:0] a);
        iMMU_REQ  = 1'b1;
        iMMU_ADDR = a;
        tick();
        iMMU_REQ  = 1'b0;
    endtask

    // Waits for a memory request, stalls it, accepts it, then returns d after lat cycles.
    task automatic mem_serve(input int stall, input int lat, input logic [63:0] d,
                             output logic [31:0] addr, output int req_cycles, output bit addr_stable);
        int n;
        n = 0;
        req_cycles  = 0;
        addr_stable = 1'b1;
        while (!oMEM_REQ && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_seen", 64'(oMEM_REQ), 64'd1);
        addr = oMEM_ADDR;
        for (int i = 0; i < stall; i++) begin
            if (oMEM_REQ) req_cycles++;
            if (oMEM_ADDR !== addr) addr_stable = 1'b0;
            tick();
        end
        if (oMEM_REQ) req_cycles++;
        if (oMEM_ADDR !== addr) addr_stable = 1'b0;
        iMEM_LOCK = 1'b0;
        tick();
        iMEM_LOCK = 1'b1;
        for (int i = 1; i < lat; i++) begin
            if (oMEM_REQ) req_cycles++;
            tick();
        end
        if (oMEM_REQ) req_cycles++;
        chk("vld_before_mem", 64'(oMMU_VALID), 64'd0);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = d;
        tick();
        iMEM_VALID = 1'b0;
    endtask

    task automatic mmu_take(input logic [63:0] d, input string t);
        chk({t, ".vld"}, 64'(oMMU_VALID), 64'd1);
        chk({t, ".dat"}, oMMU_DATA, d);
        iMMU_LOCK = 1'b0;
        tick();
        iMMU_LOCK = 1'b1;
    endtask

    logic [31:0] a;
    int          rc;
    bit          st;
    bit          acc [5];
    logic [63:0] d;
    int          wc;
    int          n;
    bit          seen_v;
    bit          seen_r;

    // Random-phase model state
    logic [31:0] req_q [$];
    bit          pending;
    bit          pend0;
    bit          deliver;
    int          wcnt;
    logic [31:0] paddr;
    bit          exp_vld;
    bit          hold;
    logic [63:0] hold_dat;
    bit          active;
    int          resp_n;

    initial begin
        iRESET     = 1'b1;
        iFLUSH     = 1'b0;
        iMMU_REQ   = 1'b0;
        iMMU_ADDR  = '0;
        iMMU_LOCK  = 1'b1;
        iMEM_LOCK  = 1'b1;
        iMEM_VALID = 1'b0;
        iMEM_DATA  = '0;
        tick();
        tick();
        chk_reset_outputs("rst");
        iRESET = 1'b0;
        tick();

        // Single request
        push_req(32'h0000_1005);
        mem_serve(0, 3, 64'hDEAD_BEEF_0123_4567, a, rc, st);
        chk("single.addr", 64'(a), 64'h0000_1004);
        chk("single.req_cycles", 64'(rc), 64'd1);
        mmu_take(64'hDEAD_BEEF_0123_4567, "single");
        chk("single.vld_drop", 64'(oMMU_VALID), 64'd0);

        // Memory and MMU backpressure
        push_req(32'h2468_ACE1);
        mem_serve(5, 1, 64'h0BAD_F00D_CAFE_0001, a, rc, st);
        chk("bp.addr", 64'(a), 64'h2468_ACE0);
        chk("bp.req_cycles", 64'(rc), 64'd6);
        chk("bp.addr_stable", 64'(st), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bp.hold_vld", 64'(oMMU_VALID), 64'd1);
            chk("bp.hold_dat", oMMU_DATA, 64'h0BAD_F00D_CAFE_0001);
            tick();
        end
        mmu_take(64'h0BAD_F00D_CAFE_0001, "bp");

        // Full FIFO with memory stalled
        for (int i = 0; i < 5; i++) begin
            iMMU_REQ  = 1'b1;
            iMMU_ADDR = 32'h100 * (i + 1);
            acc[i]    = !oMMU_LOCK;
            tick();
        end
        iMMU_REQ = 1'b0;
        chk("full.lock", 64'(oMMU_LOCK), 64'd1);
        chk("full.acc4", 64'(acc[3]), 64'd1);
        chk("full.rej5", 64'(acc[4]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            d = {32'hA5A5_0000 + k, 32'h100 * (k + 1)};
            mem_serve(0, 2, d, a, rc, st);
            chk("full.addr", 64'(a), 64'(32'h100 * (k + 1)));
            mmu_take(d, "full.order");
        end
        chk("full.unlock", 64'(oMMU_LOCK), 64'd0);
        chk("full.idle", 64'(oMEM_REQ), 64'd0);

        // Watchdog timeout
        push_req(32'h0000_3000);
        push_req(32'h0000_3008);
        chk("to.req", 64'(oMEM_REQ), 64'd1);
        iMEM_LOCK = 1'b0;
        tick();
        iMEM_LOCK = 1'b1;
        wc = 0;
        n  = 0;
        while (!oERROR && n < 40) begin
            if (!oMEM_LOCK) wc++;
            tick();
            n++;
        end
        chk("to.wait_cycles", 64'(wc), 64'(TIMEOUT));
        chk("to.err", 64'(oERROR), 64'd1);
        chk("to.vld", 64'(oMMU_VALID), 64'd1);
        chk("to.dat", oMMU_DATA, 64'd0);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = 64'hFFFF_EEEE_DDDD_CCCC;
        tick();
        iMEM_VALID = 1'b0;
        chk("to.err_pulse", 64'(oERROR), 64'd0);
        chk("to.late_dat", oMMU_DATA, 64'd0);
        mmu_take(64'd0, "to.resp");
        mem_serve(0, 2, 64'h1357_9BDF_2468_ACE0, a, rc, st);
        chk("to.next_addr", 64'(a), 64'h0000_3008);
        mmu_take(64'h1357_9BDF_2468_ACE0, "to.next");

        // Reset while a fetch is outstanding
        push_req(32'h0000_4000);
        push_req(32'h0000_4010);
        push_req(32'h0000_4020);
        chk("rw.req", 64'(oMEM_REQ), 64'd1);
        iMEM_LOCK = 1'b0;
        tick();
        iMEM_LOCK = 1'b1;
        chk("rw.in_wait", 64'(oMEM_LOCK), 64'd0);
        iRESET = 1'b1;
        tick();
        chk_reset_outputs("rw");
        iRESET     = 1'b0;
        iMEM_VALID = 1'b1;
        iMEM_DATA  = 64'h7777_6666_5555_4444;
        tick();
        iMEM_VALID = 1'b0;
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_v |= oMMU_VALID;
            seen_r |= oMEM_REQ;
            tick();
        end
        chk("rw.no_vld", 64'(seen_v), 64'd0);
        chk("rw.no_req", 64'(seen_r), 64'd0);

`ifdef MMU_PTW_LINE_CACHE_EN
        // Line cache hit and flush
        push_req(32'h0000_2000);
        mem_serve(0, 2, line_data(32'h0000_2000), a, rc, st);
        mmu_take(line_data(32'h0000_2000), "c.first");
        push_req(32'h0000_2001);
        chk("c.hit_vld", 64'(oMMU_VALID), 64'd1);
        chk("c.hit_noreq", 64'(oMEM_REQ), 64'd0);
        mmu_take(line_data(32'h0000_2001), "c.hit");
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        push_req(32'h0000_2001);
        chk("c.flush_miss", 64'(oMEM_REQ), 64'd1);
        mem_serve(0, 2, line_data(32'h0000_2001), a, rc, st);
        mmu_take(line_data(32'h0000_2001), "c.refetch");
`endif

        // Randomized traffic against an in-order transaction model
        pending = 1'b0;
        exp_vld = 1'b0;
        hold    = 1'b0;
        resp_n  = 0;
        wcnt    = 0;
        paddr   = '0;
        for (int cyc = 0; cyc < 3500; cyc++) begin
            active = (cyc < 2500);
            if (!active && req_q.size() == 0 && !pending) break;

            if (exp_vld) begin
                chk("rand.vld_after_mem", 64'(oMMU_VALID), 64'd1);
                chk("rand.dat_after_mem", oMMU_DATA, line_data(paddr));
            end
            if (hold) begin
                chk("rand.hold_vld", 64'(oMMU_VALID), 64'd1);
                chk("rand.hold_dat", oMMU_DATA, hold_dat);
            end
            chk("rand.mmu_lock", 64'(oMMU_LOCK), 64'(req_q.size() == DEPTH));
            chk("rand.mem_lock", 64'(oMEM_LOCK), 64'(!pending));

            iMMU_REQ  = active && ($urandom_range(0, 2) == 0);
            iMMU_ADDR = 32'h0000_5000 + $urandom_range(0, 15);
            iMMU_LOCK = ($urandom_range(0, 2) == 0);
            iMEM_LOCK = ($urandom_range(0, 2) == 0);
            iFLUSH    = ($urandom_range(0, 7) == 0);

            pend0   = pending;
            deliver = 1'b0;
            if (pending) begin
                if (wcnt <= 1) begin
                    deliver    = 1'b1;
                    iMEM_VALID = 1'b1;
                    iMEM_DATA  = line_data(paddr);
                    pending    = 1'b0;
                end else begin
                    wcnt--;
                    iMEM_VALID = 1'b0;
                end
            end else begin
                iMEM_VALID = ($urandom_range(0, 9) == 0);
                iMEM_DATA  = {$urandom, $urandom};
            end
            exp_vld = deliver;

            if (oMEM_REQ && !iMEM_LOCK) begin
                chk("rand.one_outstanding", 64'(pend0), 64'd0);
                chk("rand.mem_addr", 64'(oMEM_ADDR),
                    64'((req_q.size() > 0) ? line_of(req_q[0]) : 32'hFFFF_FFFF));
                pending = 1'b1;
                paddr   = oMEM_ADDR;
                wcnt    = $urandom_range(1, 6);
            end

            if (oMMU_VALID && !iMMU_LOCK) begin
                chk("rand.resp_dat", oMMU_DATA,
                    (req_q.size() > 0) ? line_data(req_q[0]) : ~oMMU_DATA);
                if (req_q.size() > 0) void'(req_q.pop_front());
                resp_n++;
            end

            hold     = oMMU_VALID && iMMU_LOCK;
            hold_dat = oMMU_DATA;

            if (iMMU_REQ && !oMMU_LOCK) req_q.push_back(iMMU_ADDR);

            tick();
        end
        iMMU_REQ   = 1'b0;
        iMEM_VALID = 1'b0;
        iFLUSH     = 1'b0;
        chk("rand.drained", 64'(req_q.size()), 64'd0);
        chk("rand.activity", 64'(resp_n > 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
